// File: rtl/ysyx_23060201_ifu_mc_pkg.sv
// Shared definitions for the multi-cycle fetch unit: FSM encoding and
// default fetch-window parameters.
package ysyx_23060201_ifu_mc_pkg;

  typedef enum logic [2:0] {
    IFU_IDLE  = 3'd0,
    IFU_REQ   = 3'd1,
    IFU_WAIT  = 3'd2,
    IFU_OUT   = 3'd3,
    IFU_EXEC  = 3'd4,
    IFU_FAULT = 3'd5
  } ifu_state_e;

  localparam int          DEF_XLEN     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEF_MBASE    = 32'h8000_0000;
  localparam logic [31:0] DEF_MSIZE    = 32'h0800_0000;
  localparam int          DEF_CNT_W    = 64;

endpackage

// File: rtl/ysyx_23060201_addr_chk.sv
// Fetch-address legality: inside [mbase, mbase+msize) and word aligned.
module ysyx_23060201_addr_chk #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] mbase,
  input  logic [XLEN-1:0] msize,
  output logic            legal
);

  // One extra bit so a window ending exactly at 2^XLEN does not wrap to zero.
  logic [XLEN:0] limit;

  assign limit = {1'b0, mbase} + {1'b0, msize};
  assign legal = (addr >= mbase) && ({1'b0, addr} < limit) && (addr[1:0] == 2'b00);

endmodule

// File: rtl/ysyx_23060201_ifu_mc.sv
// Multi-cycle instruction fetch unit: owns the PC, fetches over a valid/ready
// memory port, hands the word to IDU and waits for EXU to commit the next PC.
module ysyx_23060201_ifu_mc
  import ysyx_23060201_ifu_mc_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [XLEN-1:0] MBASE    = DEF_MBASE,
  parameter logic [XLEN-1:0] MSIZE    = DEF_MSIZE,
  parameter int              CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_data,
  input  logic             mem_rsp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  pc,
  input  logic             commit_valid,
  input  logic [XLEN-1:0]  commit_dnpc,
  output logic             fault,
  output logic [XLEN-1:0]  fault_pc,
  output logic [CNT_W-1:0] retired
);

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both high; once raised, valid and its payload hold until that edge.
  ifu_state_e      state;
  logic [XLEN-1:0] pc_nxt;
  logic            nxt_legal;

  // PC as it will be after this edge; checking it here lets mem_req_valid be
  // registered on entry to REQ, so an illegal PC never raises it.
  assign pc_nxt = (state == IFU_EXEC && commit_valid) ? commit_dnpc : pc;

  ysyx_23060201_addr_chk #(.XLEN(XLEN)) u_addr_chk (
    .addr  (pc_nxt),
    .mbase (MBASE),
    .msize (MSIZE),
    .legal (nxt_legal)
  );

  assign mem_req_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IFU_IDLE;
      pc            <= RESET_PC;
      inst          <= 32'd0;
      inst_valid    <= 1'b0;
      mem_req_valid <= 1'b0;
      fault         <= 1'b0;
      fault_pc      <= '0;
      retired       <= '0;
    end else begin
      case (state)
        IFU_IDLE: begin
          state         <= IFU_REQ;
          mem_req_valid <= nxt_legal;
        end
        IFU_REQ: begin
          if (!nxt_legal) begin
            state    <= IFU_FAULT;
            fault    <= 1'b1;
            fault_pc <= pc;
          end else if (mem_req_ready) begin
            state         <= IFU_WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        IFU_WAIT: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_err) begin
              state    <= IFU_FAULT;
              fault    <= 1'b1;
              fault_pc <= pc;
            end else begin
              state      <= IFU_OUT;
              inst       <= mem_rsp_data;
              inst_valid <= 1'b1;
            end
          end
        end
        IFU_OUT: begin
          if (inst_ready) begin
            state      <= IFU_EXEC;
            inst_valid <= 1'b0;
          end
        end
        IFU_EXEC: begin
          if (commit_valid) begin
            state         <= IFU_REQ;
            pc            <= commit_dnpc;
            retired       <= retired + CNT_W'(1);
            mem_req_valid <= nxt_legal;
          end
        end
        IFU_FAULT: begin
          state <= IFU_FAULT;
        end
        default: begin
          state         <= IFU_IDLE;
          mem_req_valid <= 1'b0;
          inst_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060201_ifu_mc.md
# ysyx_23060201_ifu_mc

Multi-cycle instruction fetch unit with a parametrised XLEN, reset vector and legal fetch window. It replaces the single-cycle PC register and combinational instruction-memory read in the core top. It owns the PC and fetches over a valid/ready memory port. It hands each instruction to IDU over a valid/ready port, then waits for EXU to commit the next PC. Illegal fetches raise a sticky fault, and a retired-instruction counter is provided.

## Interface
Parameters:
- XLEN, 32, data/address width
- RESET_PC, 32'h8000_0000, PC after reset
- MBASE, 32'h8000_0000, lowest legal fetch address
- MSIZE, 32'h0800_0000, legal window size in bytes (window is MBASE to MBASE+MSIZE-1)
- CNT_W, 64, retired-counter width

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- mem_req_valid  out  1  fetch request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  fetch address, equal to pc
- mem_rsp_valid  in  1  response data valid
- mem_rsp_data  in  32  instruction word
- mem_rsp_err  in  1  bus error, qualified by mem_rsp_valid
- inst_valid  out  1  instruction available to IDU
- inst_ready  in  1  IDU accepts instruction
- inst  out  32  captured instruction
- pc  out  XLEN  PC of the current instruction
- commit_valid  in  1  EXU finished the current instruction
- commit_dnpc  in  XLEN  next PC from EXU
- fault  out  1  sticky fetch fault
- fault_pc  out  XLEN  PC that faulted
- retired  out  CNT_W  count of committed instructions

## Operation
FSM states: IDLE, REQ, WAIT, OUT, EXEC, FAULT.

- **IDLE**
  - This is the reset state.
  - Unconditionally go to REQ on the next cycle.
- **REQ**
  - If pc is outside [MBASE, MBASE+MSIZE) or pc[1:0]!=0: go to FAULT without issuing a request. Load fault_pc<=pc.
  - Otherwise assert mem_req_valid. Hold it and mem_req_addr stable until mem_req_ready, then go to WAIT.
- **WAIT**
  - The response is sampled only in this state; mem_rsp_ready is implicitly 1.
  - On mem_rsp_valid with mem_rsp_err=1: go to FAULT and load fault_pc<=pc.
  - On mem_rsp_valid with mem_rsp_err=0: inst<=mem_rsp_data, go to OUT.
- **OUT**
  - Assert inst_valid. Hold inst and pc stable until inst_ready.
  - On inst_ready, go to EXEC.
- **EXEC**
  - On commit_valid: pc<=commit_dnpc, retired<=retired+1 (wraps at 2^CNT_W), go to REQ.
- **FAULT**
  - Terminal state: fault=1, all valids 0. Only rst leaves it.

Rules for misplaced or simultaneous events:
- commit_valid outside EXEC is ignored, with no PC or counter change.
- mem_rsp_valid outside WAIT is ignored.
- inst_ready outside OUT is ignored.
- commit_dnpc is not range-checked at commit; it is checked in the following REQ.
- Arithmetic is unsigned. The window upper bound is computed at XLEN+1 bits so MBASE+MSIZE=2^XLEN does not wrap.

## Timing
- Reset values (applied at the clock edge where rst=1):
  - state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, mem_req_valid=0
  - fault=0, fault_pc=0, retired=0
- rst asserted in any state, including mid-request or FAULT, returns to IDLE on that edge. Memory shares rst, so no stale response can arrive afterwards.
- Outputs are driven from state and registers only; there is no combinational path from any input to any output.
- mem_req_valid goes high the cycle after leaving IDLE.
- The earliest response is the cycle after the request handshake.
- The best-case loop is 4 cycles per instruction (REQ, WAIT, OUT, EXEC), with ready, response and commit each asserted at first opportunity.
- pc updates at the EXEC-to-REQ edge, so the new mem_req_addr is visible in the same cycle mem_req_valid rises.

## Structure
- Add to defines.v:
  - FSM state encodings (3-bit, named IFU_IDLE..IFU_FAULT)
  - RESET_PC and MSIZE defaults alongside the existing MBASE
- One combinational sub-module, ysyx_23060201_addr_chk:
  - inputs: addr, MBASE, MSIZE
  - output: legal (in-window and word-aligned)
- The FSM, PC, instruction register and counter stay in the top-level block.

## Test plan
- Reset release, memory always ready, 1-cycle response of 32'h0000_0413, IDU ready, commit dnpc=pc+4 each time:
  - mem_req_addr sequence is 0x8000_0000, 0x8000_0004, …
  - one instruction every 4 cycles
  - retired=3 after the third commit
- mem_req_ready held low 5 cycles: mem_req_valid and mem_req_addr stay stable, then WAIT is entered exactly one cycle after ready.
- inst_ready low 3 cycles in OUT: inst, pc and inst_valid stay stable; commit_valid pulsed during OUT is ignored (retired unchanged).
- commit_dnpc=0x7FFF_FFFC:
  - next REQ goes to FAULT with no mem_req_valid
  - fault=1, fault_pc=0x7FFF_FFFC
  - repeat with dnpc=0x8000_0002 (misaligned) and get the same fault behaviour
- mem_rsp_err=1 on the response to 0x8000_0008: fault=1, fault_pc=0x8000_0008, inst_valid stays 0.
- rst pulsed while in WAIT and while in FAULT:
  - all outputs return to their reset values
  - pc=0x8000_0000
  - fetch restarts two cycles after rst falls
